// File: rtl/div_seq.sv
// Sequencer for the iterative radix-2 divider (DIV/DIVU): 32 shift/subtract steps, sign fix-up, stall handshake.
// Optional macro DIV_ZERO_FLAG_EN adds the div_zero_o output flagging divide-by-zero results.
module div_seq #(
    parameter int DW    = 32,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              signed_div_i,
    input  logic [DW-1:0]     opdata1_i,
    input  logic [DW-1:0]     opdata2_i,
    input  logic              start_i,
    input  logic              annul_i,
    output logic [2*DW-1:0]   result_o,
    output logic              ready_o,
`ifdef DIV_ZERO_FLAG_EN
    output logic              div_zero_o,
`endif
    output logic              stallreq_o
);

    typedef enum logic [1:0] {
        ST_FREE   = 2'b00,
        ST_BYZERO = 2'b01,
        ST_ON     = 2'b10,
        ST_END    = 2'b11
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DW-1:0]     rem_r;
    logic [DW-1:0]     quo_r;
    logic [DW-1:0]     dvs_r;
    logic              neg_quo_r;
    logic              neg_rem_r;
    logic [2*DW-1:0]   result_r;
    logic              ready_r;

    logic [DW:0]       shifted_s;
    logic [DW+1:0]     trial_s;
    logic [DW-1:0]     rem_nxt_s;
    logic [DW-1:0]     quo_nxt_s;
    logic [DW-1:0]     rem_fix_s;
    logic [DW-1:0]     quo_fix_s;

    function automatic logic [DW-1:0] negate(input logic [DW-1:0] v);
        return {DW{1'b0}} - v;
    endfunction

    function automatic logic [DW-1:0] magnitude(input logic [DW-1:0] v, input logic is_signed);
        return (is_signed && v[DW-1]) ? negate(v) : v;
    endfunction

    // One shift/subtract step on {rem, quotient} plus the sign-corrected final values.
    always_comb begin
        shifted_s = {rem_r, quo_r[DW-1]};
        trial_s   = {1'b0, shifted_s} - {2'b00, dvs_r};
        rem_nxt_s = {DW{1'b0}};
        if (trial_s[DW+1]) begin
            rem_nxt_s = shifted_s[DW-1:0];
        end else begin
            rem_nxt_s = trial_s[DW-1:0];
        end
        quo_nxt_s = {quo_r[DW-2:0], ~trial_s[DW+1]};
        quo_fix_s = neg_quo_r ? negate(quo_nxt_s) : quo_nxt_s;
        rem_fix_s = neg_rem_r ? negate(rem_nxt_s) : rem_nxt_s;
    end

    // Control FSM with datapath registers and registered result/ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_FREE;
            cnt_r     <= {CNT_W{1'b0}};
            rem_r     <= {DW{1'b0}};
            quo_r     <= {DW{1'b0}};
            dvs_r     <= {DW{1'b0}};
            neg_quo_r <= 1'b0;
            neg_rem_r <= 1'b0;
            result_r  <= {2*DW{1'b0}};
            ready_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_FREE: begin
                    ready_r  <= 1'b0;
                    result_r <= {2*DW{1'b0}};
                    if (start_i && !annul_i) begin
                        if (opdata2_i == {DW{1'b0}}) begin
                            state_r <= ST_BYZERO;
                        end else begin
                            state_r   <= ST_ON;
                            cnt_r     <= {CNT_W{1'b0}};
                            rem_r     <= {DW{1'b0}};
                            quo_r     <= magnitude(opdata1_i, signed_div_i);
                            dvs_r     <= magnitude(opdata2_i, signed_div_i);
                            neg_quo_r <= signed_div_i & (opdata1_i[DW-1] ^ opdata2_i[DW-1]);
                            neg_rem_r <= signed_div_i & opdata1_i[DW-1];
                        end
                    end else begin
                        state_r <= ST_FREE;
                    end
                end
                ST_BYZERO: begin
                    if (annul_i) begin
                        state_r <= ST_FREE;
                    end else begin
                        state_r  <= ST_END;
                        ready_r  <= 1'b1;
                        result_r <= {2*DW{1'b0}};
                    end
                end
                ST_ON: begin
                    if (annul_i || !start_i) begin
                        state_r <= ST_FREE;
                    end else begin
                        rem_r <= rem_nxt_s;
                        quo_r <= quo_nxt_s;
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (cnt_r == CNT_W'(DW-1)) begin
                            state_r  <= ST_END;
                            ready_r  <= 1'b1;
                            result_r <= {rem_fix_s, quo_fix_s};
                        end else begin
                            state_r <= ST_ON;
                        end
                    end
                end
                ST_END: begin
                    if (annul_i || !start_i) begin
                        state_r  <= ST_FREE;
                        ready_r  <= 1'b0;
                        result_r <= {2*DW{1'b0}};
                    end else begin
                        state_r <= ST_END;
                    end
                end
                default: begin
                    state_r  <= ST_FREE;
                    ready_r  <= 1'b0;
                    result_r <= {2*DW{1'b0}};
                end
            endcase
        end
    end

`ifdef DIV_ZERO_FLAG_EN
    logic div_zero_r;

    // Flag is raised on the BYZERO->END edge and held only while that result is presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_zero_r <= 1'b0;
        end else begin
            div_zero_r <= ((state_r == ST_BYZERO) & ~annul_i) |
                          ((state_r == ST_END) & start_i & ~annul_i & div_zero_r);
        end
    end

    assign div_zero_o = div_zero_r;
`endif

    assign result_o   = result_r;
    assign ready_o    = ready_r;
    assign stallreq_o = start_i & ~annul_i & ~ready_r;

endmodule

// File: tb/tb_div_seq.sv
// Randomized scoreboard bench for div_seq: driver pushes expected results, monitor checks on ready.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stallreq;
`ifdef DIV_ZERO_FLAG_EN
    logic        div_zero;
`endif

    div_seq dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready),
`ifdef DIV_ZERO_FLAG_EN
        .div_zero_o   (div_zero),
`endif
        .stallreq_o   (stallreq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic        dz;
        int          issue;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    logic        mon_en = 1'b0;
    logic        ready_q = 1'b0;
    logic [63:0] held_res = 64'd0;
    logic        held_dz  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference quotient/remainder from plain integer arithmetic.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a;
                r = 32'd0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on each new ready and checks hold/idle behaviour.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ready && !ready_q) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_ready: got ready=1 result=%h expected no result", result);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", result, e.res);
                    chk("latency", 64'(cyc - e.issue), 64'(e.lat));
                    chk("stall_at_ready", {63'd0, stallreq}, 64'd0);
                    held_res = e.res;
                    held_dz  = e.dz;
`ifdef DIV_ZERO_FLAG_EN
                    chk("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
`endif
                end
            end else if (ready) begin
                chk("hold_stable", result, held_res);
`ifdef DIV_ZERO_FLAG_EN
                chk("div_zero_hold", {63'd0, div_zero}, {63'd0, held_dz});
`endif
            end else begin
                chk("idle_zero", result, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
                chk("div_zero_idle", {63'd0, div_zero}, 64'd0);
`endif
            end
            ready_q = ready;
        end
    end

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int hold, input logic end_annul);
        exp_t e;
        e.res   = ref_div(a, b, s);
        e.dz    = (b == 32'd0);
        e.lat   = (b == 32'd0) ? 2 : 33;
        opdata1    = a;
        opdata2    = b;
        signed_div = s;
        start      = 1'b1;
        e.issue    = cyc;
        sb.push_back(e);
        step;
        chk("stall_busy", {63'd0, stallreq}, 64'd1);
        for (int i = 0; i < 40 && !ready; i++) step;
        chk("ready_seen", {63'd0, ready}, 64'd1);
        repeat (hold) step;
        if (end_annul) begin
            annul = 1'b1;
            step;
            chk("annul_end_drop", {63'd0, ready}, 64'd0);
            annul = 1'b0;
            start = 1'b0;
            step;
        end else begin
            start = 1'b0;
            step;
            chk("ready_drop", {63'd0, ready}, 64'd0);
        end
    endtask

    // kind 0: annul, 1: drop start, 2: synchronous reset; no result may appear.
    task automatic do_abort(input logic [31:0] a, input logic [31:0] b, input logic s,
                            input int n, input int kind);
        opdata1    = a;
        opdata2    = b;
        signed_div = s;
        start      = 1'b1;
        repeat (n) step;
        if (kind == 0) begin
            annul = 1'b1;
            #1;
            chk("stall_annul", {63'd0, stallreq}, 64'd0);
            step;
            annul = 1'b0;
            start = 1'b0;
        end else if (kind == 1) begin
            start = 1'b0;
            step;
        end else begin
            rst   = 1'b1;
            start = 1'b0;
            step;
            rst   = 1'b0;
            chk("rst_mid_ready", {63'd0, ready}, 64'd0);
            chk("rst_mid_result", result, 64'd0);
        end
        repeat (40) step;
        chk("abort_no_ready", {63'd0, ready}, 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
        opdata1 = 32'd0; opdata2 = 32'd0;
        repeat (3) step;
        rst = 1'b0;
        chk("reset_ready", {63'd0, ready}, 64'd0);
        chk("reset_result", result, 64'd0);
        chk("reset_stall", {63'd0, stallreq}, 64'd0);
        mon_en = 1'b1;

        do_op(32'd100, 32'd7, 1'b0, 0, 1'b0);
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 1'b0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 1'b0);
        do_op(32'h0000_1234, 32'd0, 1'b0, 1, 1'b0);
        do_op(32'h0000_1234, 32'd0, 1'b1, 0, 1'b0);
        do_abort(32'd1000, 32'd3, 1'b0, 10, 0);
        do_op(32'd9, 32'd3, 1'b0, 0, 1'b0);
        do_abort(32'd1000, 32'd3, 1'b0, 20, 2);
        do_abort(32'd12345, 32'd17, 1'b1, 15, 1);
        do_abort(32'd5, 32'd0, 1'b0, 1, 0);
        do_op(32'd77, 32'd5, 1'b1, 5, 1'b0);
        do_op(32'hFFFF_FF00, 32'd3, 1'b1, 2, 1'b1);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'd1;
                2:       b = 32'hFFFF_FFFF;
                3:       b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            do_op(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 4), 1'($urandom_range(0, 5) == 0));
        end

        repeat (5) step;
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
